// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: buffers (A,B) operand pairs and streams them into a MAC PE under valid/ready.
module pe_operand_feeder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int PE_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_a_i,
    input  logic [DATA_W-1:0] wr_b_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              pe_rdy_i,
    output logic              pe_clr_o,
    output logic              pe_vld_o,
    output logic [DATA_W-1:0] pe_a_o,
    output logic [DATA_W-1:0] pe_b_o,
    output logic              busy_o,
    output logic              done_o
);
    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, DONE} state_e;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
    localparam logic [3:0]      LAT     = 4'(PE_LAT);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_a [DEPTH];
    logic [DATA_W-1:0] buf_b [DEPTH];
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pe_clr_d, pe_vld_d, busy_d, done_d;
    logic [DATA_W-1:0] pe_a_d, pe_b_d;
    logic              xfer, last;

    assign xfer = state_q == STREAM && pe_rdy_i;
    assign last = {1'b0, idx_q} == len_q - ONE_L;

    always_ff @(posedge clk_i)
        if (wr_en_i && !busy_o) begin
            buf_a[wr_addr_i] <= wr_a_i;
            buf_b[wr_addr_i] <= wr_b_i;
        end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            pe_clr_o <= 1'b0;
            pe_vld_o <= 1'b0;
            pe_a_o   <= '0;
            pe_b_o   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            pe_clr_o <= pe_clr_d;
            pe_vld_o <= pe_vld_d;
            pe_a_o   <= pe_a_d;
            pe_b_o   <= pe_b_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
        end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = len_i == '0 ? DONE : CLR;
                len_d   = len_i > DEPTH_L ? DEPTH_L : len_i;
                idx_d   = '0;
            end
            CLR: state_d = STREAM;
            STREAM: if (xfer) begin
                state_d = last ? DRAIN : STREAM;
                idx_d   = last ? idx_q : idx_q + ADDR_W'(1);
                cnt_d   = last ? LAT : cnt_q;
            end
            DRAIN: begin
                state_d = cnt_q == '0 ? DONE : DRAIN;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        pe_clr_d = state_d == CLR;
        pe_vld_d = state_d == STREAM;
        pe_a_d   = pe_vld_d ? buf_a[idx_d] : '0;
        pe_b_d   = pe_vld_d ? buf_b[idx_d] : '0;
        busy_d   = state_d != IDLE;
        done_d   = state_d == DONE;
    end
endmodule

// File: tb/tb_pe_operand_feeder.sv
// tb_pe_operand_feeder: table-driven cycle checks plus directed corner-case sequences.
module tb_pe_operand_feeder;
    localparam int LAT = 1;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        wr_en = 1'b0, start = 1'b0, pe_rdy = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_a = '0, wr_b = '0;
    logic [4:0]  len = '0;
    logic        pe_clr, pe_vld, busy, done;
    logic [31:0] pe_a, pe_b;
    int          tests = 0, fails = 0;
    logic [63:0] acc = '0;
    logic [31:0] xa[$];
    logic        seen_done;

    typedef struct {
        logic st; logic [4:0] ln; logic rdy;
        logic clr, vld; logic [31:0] a, b; logic bsy, dn, ac;
    } vec_t;
    vec_t tbl[$];

    pe_operand_feeder #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .PE_LAT(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_a_i(wr_a), .wr_b_i(wr_b), .start_i(start), .len_i(len), .pe_rdy_i(pe_rdy),
        .pe_clr_o(pe_clr), .pe_vld_o(pe_vld), .pe_a_o(pe_a), .pe_b_o(pe_b),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input int ad, input int a, input int b);
        wr_en = 1'b1; wr_addr = 4'(ad); wr_a = a; wr_b = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic add(input logic st, input int ln, input logic rdy, input logic clr,
                       input logic vld, input int a, input int b, input logic bsy,
                       input logic dn, input logic ac);
        tbl.push_back('{st, 5'(ln), rdy, clr, vld, a, b, bsy, dn, ac});
    endtask

    task automatic run_to_done(input int max);
        xa.delete();
        seen_done = 1'b0;
        for (int c = 0; c < max && !seen_done; c++) begin
            if (pe_vld && pe_rdy) xa.push_back(pe_a);
            step();
            if (done) seen_done = 1'b1;
        end
    endtask

    initial begin
        logic any;
        // full run, pe_rdy held high
        add(1,4,1, 1,0,0,0,1,0,0);
        add(0,0,1, 0,1,1,2,1,0,0);
        add(0,0,1, 0,1,2,2,1,0,0);
        add(0,0,1, 0,1,3,2,1,0,0);
        add(0,0,1, 0,1,4,2,1,0,0);
        add(0,0,1, 0,0,0,0,1,0,0);
        add(0,0,1, 0,0,0,0,1,0,0);
        add(0,0,1, 0,0,0,0,1,1,1);
        add(0,0,0, 0,0,0,0,0,0,0);
        // stalled run: rdy 1,0,0,1,0,1,1 while streaming
        add(1,4,0, 1,0,0,0,1,0,0);
        add(0,0,0, 0,1,1,2,1,0,0);
        add(0,0,1, 0,1,2,2,1,0,0);
        add(0,0,0, 0,1,2,2,1,0,0);
        add(0,0,0, 0,1,2,2,1,0,0);
        add(0,0,1, 0,1,3,2,1,0,0);
        add(0,0,0, 0,1,3,2,1,0,0);
        add(0,0,1, 0,1,4,2,1,0,0);
        add(0,0,1, 0,0,0,0,1,0,0);
        add(0,0,0, 0,0,0,0,1,0,0);
        add(0,0,0, 0,0,0,0,1,1,1);
        add(0,0,0, 0,0,0,0,0,0,0);
        // zero-length run
        add(1,0,1, 0,0,0,0,1,1,0);
        add(0,0,1, 0,0,0,0,0,0,0);

        #3 rst_n = 1'b0;
        step();
        step();
        chk("reset outputs", {pe_clr, pe_vld, pe_a, pe_b, busy, done}, '0);
        #2 rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) wr(i, i + 1, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; len = tbl[i].ln; pe_rdy = tbl[i].rdy;
            if (pe_vld && pe_rdy) acc += 64'(pe_a) * 64'(pe_b);
            step();
            chk($sformatf("row %0d", i), {pe_clr, pe_vld, pe_a, pe_b, busy, done},
                {tbl[i].clr, tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].bsy, tbl[i].dn});
            if (tbl[i].ac) begin
                chk($sformatf("row %0d result", i), acc, 64'd20);
                acc = '0;
            end
        end
        start = 1'b0;

        // write and second start while streaming are ignored
        start = 1'b1; len = 5'd4; pe_rdy = 1'b0;
        step();
        start = 1'b0;
        step();
        wr_en = 1'b1; wr_addr = 4'd0; wr_a = 99; wr_b = 99; start = 1'b1; len = 5'd2;
        step();
        wr_en = 1'b0; start = 1'b0;
        chk("hold under stall", {pe_vld, pe_a, pe_b}, {1'b1, 32'd1, 32'd2});
        pe_rdy = 1'b1;
        run_to_done(20);
        chk("busy write run done", seen_done, 1'b1);
        chk("busy write run xfers", xa.size(), 4);
        any = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            any |= busy | pe_clr | pe_vld | done;
        end
        chk("no extra run", any, 1'b0);
        start = 1'b1; len = 5'd1;
        step();
        start = 1'b0;
        step();
        chk("entry 0 kept", {pe_vld, pe_a, pe_b}, {1'b1, 32'd1, 32'd2});
        run_to_done(10);
        chk("entry 0 run done", seen_done, 1'b1);
        step();

        // asynchronous reset in the middle of a stream
        start = 1'b1; len = 5'd4; pe_rdy = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid stream", {pe_vld, pe_a}, {1'b1, 32'd2});
        #2 rst_n = 1'b0;
        #1 chk("async reset outputs", {pe_clr, pe_vld, pe_a, pe_b, busy, done}, '0);
        any = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            any |= done | busy;
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            any |= done | busy;
        end
        chk("no done after abort", any, 1'b0);
        start = 1'b1; len = 5'd2;
        step();
        start = 1'b0;
        chk("restart clr", {pe_clr, busy}, 2'b11);
        step();
        chk("restart first pair", {pe_vld, pe_a, pe_b}, {1'b1, 32'd1, 32'd2});
        run_to_done(10);
        chk("restart done", seen_done, 1'b1);
        step();

        // len clamp, with the last write landing alongside start
        for (int i = 0; i < 15; i++) wr(i, 100 + i, i + 1);
        wr_en = 1'b1; wr_addr = 4'd15; wr_a = 115; wr_b = 16; start = 1'b1; len = 5'd20;
        step();
        wr_en = 1'b0; start = 1'b0;
        run_to_done(40);
        chk("clamp done", seen_done, 1'b1);
        chk("clamp xfers", xa.size(), 16);
        for (int i = 0; i < xa.size() && i < 16; i++)
            chk($sformatf("clamp pair %0d", i), xa[i], 32'(100 + i));
        step();
        chk("clamp idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
